// File: rtl/regfile_dump_pkg.sv
// Shared debug package for the register-file dump engine: state encoding,
// default widths and the architectural register count.
package regfile_dump_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 5;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : regfile_dump_pkg

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a (possibly wrapping) range of register
// indices through a dedicated combinational read port and streams each
// {index, value} pair over a valid/ready interface. Never writes the
// register file. All outputs come straight from flops; their next values are
// decoded from the next state so they line up with the state register.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    input  logic              abort,
    output logic [IDX_W-1:0]  rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    state_e              state_r;
    state_e              state_nx_s;
    logic [IDX_W-1:0]    cur_idx_r;
    logic [IDX_W-1:0]    cur_idx_nx_s;
    logic [IDX_W-1:0]    end_idx_r;
    logic [IDX_W-1:0]    end_idx_nx_s;
    logic                capture_s;
    logic [IDX_W-1:0]    rf_addr_r;
    logic                out_valid_r;
    logic [IDX_W-1:0]    out_idx_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                busy_r;
    logic                done_r;

    // Next-state, index counter and capture decode; abort wins everywhere but IDLE.
    always_comb begin
        state_nx_s   = state_r;
        cur_idx_nx_s = cur_idx_r;
        end_idx_nx_s = end_idx_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx_s   = ST_READ;
                    cur_idx_nx_s = first_idx;
                    end_idx_nx_s = last_idx;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SEND;
                    capture_s  = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (out_ready) begin
                    if (cur_idx_r == end_idx_r) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s   = ST_READ;
                        // Natural IDX_W-bit overflow gives the modulo-32 wrap.
                        cur_idx_nx_s = cur_idx_r + IDX_ONE;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, index bounds and registered outputs; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cur_idx_r   <= IDX_ZERO;
            end_idx_r   <= IDX_ZERO;
            rf_addr_r   <= IDX_ZERO;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cur_idx_r   <= cur_idx_nx_s;
            end_idx_r   <= end_idx_nx_s;
            rf_addr_r   <= (state_nx_s == ST_READ) ? cur_idx_nx_s : IDX_ZERO;
            out_valid_r <= (state_nx_s == ST_SEND);
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= (state_nx_s == ST_DONE);
        end
    end

    // Snapshot of the register value at the READ edge; held through SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_r  <= IDX_ZERO;
            out_data_r <= {DATA_W{1'b0}};
        end else if (capture_s) begin
            out_idx_r  <= cur_idx_r;
            out_data_r <= rf_data;
        end else begin
            out_idx_r  <= out_idx_r;
            out_data_r <= out_data_r;
        end
    end

    assign rf_addr   = rf_addr_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule : regfile_dump

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the single-cycle core's 32×32 register file. On a start pulse it walks a range of register indices through a dedicated read port and streams each `{index, value}` pair out over a valid/ready interface. It sits between the register file's debug read port and the debug transport (UART/JTAG bridge), and never writes the register file.

## Interface
- `DATA_W`, default 32, register width.
- `IDX_W`, default 5, register index width (32 registers).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to begin a dump; ignored while `busy`.
- `first_idx` in IDX_W: first register index, sampled on an accepted `start`.
- `last_idx` in IDX_W: last register index, sampled on an accepted `start`.
- `abort` in 1: terminates an active dump.
- `rf_addr` out IDX_W: address to the register file's combinational read port.
- `rf_data` in DATA_W: read data for `rf_addr`, valid in the same cycle.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: stream sink ready.
- `out_idx` out IDX_W: register index of the current word.
- `out_data` out DATA_W: captured register value.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- States:
  - **IDLE**: wait for `start`.
  - **READ**: drive `rf_addr = cur_idx` and capture `rf_data` at the clock edge.
  - **SEND**: hold `out_valid` high until a handshake completes.
  - **DONE**: assert `done` for one cycle.
- Transitions:
  - IDLE → READ on `start && !abort`. On that transition, `cur_idx <= first_idx` and `end_idx <= last_idx`.
  - READ → SEND always. At the edge, `out_data <= rf_data` and `out_idx <= cur_idx`.
  - SEND → READ on `out_valid && out_ready` when `cur_idx != end_idx`, with `cur_idx <= cur_idx + 1`.
  - SEND → DONE on a handshake when `cur_idx == end_idx`.
  - DONE → IDLE always.
- Range and wrap-around:
  - The index increments modulo 32, so 31 wraps to 0.
  - If `first_idx > last_idx`, the dump wraps, e.g. 30, 31, 0, 1.
  - The word count is `((last - first) mod 32) + 1`, so `first == last` gives exactly one word.
- x0 is read like any other index. The register file returns 0 for it, and this block forwards that value unmodified.
- Snapshot semantics: each word reflects the register file contents in its READ cycle. A write to the same register later in the dump is not reflected in an already-captured word.
- `out_data` and `out_idx` are stable while `out_valid` is high and `out_ready` is low.
- `out_valid` never drops without a handshake, with one exception: `abort`.
- Abort:
  - `abort` in READ, SEND or DONE moves the block to IDLE at the next edge.
  - `out_valid` drops and `done` is not pulsed.
  - A word presented in the abort cycle and accepted by the sink in that same cycle is counted as delivered.
- `abort` and `start` together in IDLE: the start is ignored.
- `start` while busy is ignored. The dump in progress is unaffected.
- Out-of-range behaviour is impossible: every 5-bit index is legal.

## Timing
- Reset values: state = IDLE; `rf_addr = 0`, `out_valid = 0`, `out_idx = 0`, `out_data = 0`, `busy = 0`, `done = 0`; internal `cur_idx = 0`, `end_idx = 0`.
- `rf_addr` equals `cur_idx` in READ and is 0 in all other states.
- With `start` at cycle 0 (sampled at the edge ending cycle 0):
  - READ occurs in cycle 1.
  - `out_valid` is first high in cycle 2.
- With `out_ready` held high:
  - One word is delivered every 2 cycles.
  - The k-th word (k from 1) handshakes in cycle 2k.
  - `done` is high in cycle 2N+1 and `busy` is low from cycle 2N+2.
- Backpressure: each cycle of `out_ready = 0` in SEND adds one cycle of latency, with no loss and no duplication.
- An asynchronous reset asserted mid-dump immediately forces all outputs to their reset values. The dump is not resumed after reset is released.

## Structure
- Shared debug package holds:
  - the state enum (IDLE, READ, SEND, DONE);
  - `IDX_W` and `DATA_W` defaults;
  - the register count constant of 32.
- Single flat module. The FSM and the index counter are too small to justify a sub-module.

## Test plan
- Full dump: preload `xi = 0x1000_0000 + i` for i = 1..31, then `start` with first 0, last 31 and `out_ready = 1`.
  - Expect 32 words in order: idx 0 with data 0, then idx i with data `0x1000_0000 + i`.
  - Expect `done` exactly once, at cycle 65.
- Wrap-around: first 30, last 1.
  - Expect idx sequence 30, 31, 0, 1, then `done`.
  - First = last = 7 gives a single word for x7, followed by `done`.
- Backpressure: random `out_ready`, 50% duty, over the full range.
  - Expect no lost or duplicated words, and data/idx stable while `valid && !ready`.
- Snapshot: write x5 = `0xDEAD_BEEF` in the cycle after x5's READ.
  - Expect the old x5 value in the stream.
  - A second dump returns `0xDEAD_BEEF`.
- Abort: abort in SEND of the 3rd word while `out_ready = 0`.
  - Expect `out_valid` = 0 next cycle, `busy` = 0, and no `done`.
  - A following `start` runs cleanly.
- Reset and ignored start: assert `rst_n = 0` mid-dump and expect all outputs 0 asynchronously. Separately, `start` while busy is ignored and `start` together with `abort` in IDLE does not begin a dump.
